// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: dispatches FP ops into the fpu, owns the FP register
// scoreboard, and merges fpu results onto the shared register-file write port
// behind the integer pipeline through a small skid FIFO.
module fpu_issue_ctrl #(
    parameter int WB_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [3:0]  issue_op,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_src_a,
    input  logic [4:0]  issue_src_b,
    input  logic        issue_uses_a,
    input  logic        issue_uses_b,
    input  logic [4:0]  issue_dest,
    output logic        issue_ready,
    output logic [3:0]  fpu_op,
    output logic [31:0] fpu_in_a,
    output logic [31:0] fpu_in_b,
    output logic [4:0]  fpu_in_dest,
    input  logic        fpu_div_busy,
    input  logic        fpu_valid,
    input  logic [4:0]  fpu_dest,
    input  logic [31:0] fpu_result,
    input  logic        alu_wr_en,
    output logic        wb_en,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic [31:0] pending,
    output logic        bad_op
);

    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0] OP_DIV = 4'hB;
    localparam logic [CNT_W:0] OCC_MAX = (CNT_W + 1)'(WB_DEPTH);

    // Ops the fpu actually implements; anything else is flagged and dropped.
    function automatic logic op_supported(input logic [3:0] op);
        return op inside {4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF};
    endfunction

    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [4:0]       fifo_dest [WB_DEPTH];
    logic [31:0]      fifo_data [WB_DEPTH];

    logic        hazard;
    logic        full;
    logic        div_stall;
    logic        fire;
    logic        fire_ok;
    logic        res_valid;
    logic        push;
    logic        pop;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    // Issue gating: scoreboard hazards, writeback capacity and divider occupancy.
    always_comb begin
        hazard    = (issue_uses_a & pending[issue_src_a])
                  | (issue_uses_b & pending[issue_src_b])
                  | pending[issue_dest];
        full      = ({1'b0, inflight} + {1'b0, fifo_count}) >= OCC_MAX;
        div_stall = (issue_op == OP_DIV) & (fpu_div_busy | (fpu_op == OP_DIV));
        issue_ready = ~hazard & ~full & ~div_stall;
        fire      = issue_valid & issue_ready;
        fire_ok   = fire & op_supported(issue_op);
        // A result with nothing in flight is a leftover from before reset.
        res_valid = fpu_valid & (inflight != '0);
    end

    // Write-port arbitration: integer pipeline first, then FIFO head, then bypass.
    always_comb begin
        wb_en   = 1'b0;
        wb_dest = 5'd0;
        wb_data = 32'd0;
        push    = 1'b0;
        pop     = 1'b0;
        if (alu_wr_en) begin
            push = res_valid;
        end else if (fifo_count != '0) begin
            wb_dest = fifo_dest[rd_ptr];
            wb_data = fifo_data[rd_ptr];
            wb_en   = (fifo_dest[rd_ptr] != 5'd0);
            pop     = 1'b1;
            push    = res_valid;
        end else if (res_valid) begin
            wb_dest = fpu_dest;
            wb_data = fpu_result;
            wb_en   = (fpu_dest != 5'd0);
        end
    end

    // Scoreboard masks: r0 is never tracked, writes clear on the following edge.
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (fire_ok && issue_dest != 5'd0) set_mask = 32'd1 << issue_dest;
        if (wb_en) clr_mask = 32'd1 << wb_dest;
    end

    // Control state: dispatch register, scoreboard, counters and FIFO pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            fpu_op      <= 4'd0;
            fpu_in_a    <= 32'd0;
            fpu_in_b    <= 32'd0;
            fpu_in_dest <= 5'd0;
            pending     <= 32'd0;
            inflight    <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            bad_op      <= 1'b0;
        end else begin
            fpu_op <= fire_ok ? issue_op : 4'd0;
            if (fire_ok) begin
                fpu_in_a    <= issue_a;
                fpu_in_b    <= issue_b;
                fpu_in_dest <= issue_dest;
            end
            bad_op     <= fire & ~op_supported(issue_op);
            pending    <= (pending & ~clr_mask) | set_mask;
            inflight   <= inflight + CNT_W'(fire_ok) - CNT_W'(res_valid);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // FIFO storage: data only, validity is carried by fifo_count.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_dest[wr_ptr] <= fpu_dest;
            fifo_data[wr_ptr] <= fpu_result;
        end
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sits between the decode/issue stage and the fpu block. Sequences FPU ops into the fpu and owns the floating-point register scoreboard.
- Stalls issue on RAW/WAW hazards, on a busy divider, and when writeback buffering could overflow.
- The fpu has no backpressure. Its results are merged onto the shared register-file write port, and the integer pipeline always has priority on that port.

Parameters:
- WB_DEPTH, 4, entries in the writeback skid FIFO; also the cap on in-flight plus buffered results. Power of two, ≥2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  decode presents an FPU instruction
- issue_op  in  4  8 add, 9 sub, A mul, B div, D cmp, E i2f, F f2i
- issue_a  in  32  operand A value
- issue_b  in  32  operand B value
- issue_src_a  in  5  operand A register index
- issue_src_b  in  5  operand B register index
- issue_uses_a  in  1  operand A is read
- issue_uses_b  in  1  operand B is read
- issue_dest  in  5  destination register
- issue_ready  out  1  instruction accepted this cycle (fire = issue_valid & issue_ready)
- fpu_op  out  4  op to fpu, registered; 0 = idle
- fpu_in_a  out  32  registered operand A
- fpu_in_b  out  32  registered operand B
- fpu_in_dest  out  5  registered destination
- fpu_div_busy  in  1  divider occupied
- fpu_valid  in  1  fpu result strobe
- fpu_dest  in  5  result destination
- fpu_result  in  32  result data
- alu_wr_en  in  1  integer pipeline uses the write port this cycle
- wb_en  out  1  FPU write to register file
- wb_dest  out  5  write index
- wb_data  out  32  write data
- pending  out  32  scoreboard; bit n = result for rN outstanding
- bad_op  out  1  one-cycle pulse when an unsupported op is accepted

Behaviour:
- Reset:
  - fpu_op=0, fpu_in_a/b/dest=0, pending=0, in-flight counter=0, FIFO empty, wb_en=0, bad_op=0.
  - Applies mid-operation: all tracked state is discarded.
- r0 is hardwired zero:
  - dest 0 never sets a pending bit.
  - Results for dest 0 consume FIFO/in-flight accounting but are never written (wb_en stays 0 when they reach the head).
- issue_ready (combinational) = ~hazard & ~full & ~div_stall. It is independent of issue_valid.
  - hazard = (uses_a & pending[src_a]) | (uses_b & pending[src_b]) | pending[dest]. Index 0 never matches.
  - full = inflight + fifo_count ≥ WB_DEPTH, using registered values.
  - div_stall = (issue_op==B) & (fpu_div_busy | fpu_op==B). The second term covers the registered div not yet seen by the divider.
- On fire with a valid op:
  - Next cycle: fpu_op=issue_op, operands/dest registered, pending[dest] set, inflight+1.
  - Next cycle with no fire: fpu_op=0.
- Unsupported op (0–7, C) on fire: fpu_op stays 0, no scoreboard/counter change, bad_op pulses next cycle.
- fpu_valid:
  - With inflight>0: inflight−1.
  - With inflight==0 (stale result from before reset): result dropped, no write, counter stays 0.
- Writeback, combinational each cycle:
  - If alu_wr_en: wb_en=0. Any fpu_valid result is pushed to the FIFO.
  - Else if FIFO nonempty: write the head (wb_en = head dest≠0), pop. A simultaneous fpu_valid result is pushed.
  - Else if fpu_valid: direct bypass write of fpu_dest/fpu_result, nothing stored.
  - Order is strictly FIFO.
- Scoreboard clear:
  - pending[wb_dest] clears on the cycle after wb_en. It is cleared at write, not at fpu_valid.
  - No result forwarding: an instruction reading that register issues at the earliest in the cycle after the clear.
  - Simultaneous set (fire) and clear on different registers both take effect. The same register is impossible because of the WAW check.
- Occupancy:
  - Push on a full FIFO is impossible by construction.
  - The bench asserts that inflight + fifo_count never exceeds WB_DEPTH.

Test Plan:
- Reset, then fire add (op 8) dest r3, a=0x3F800000, b=0x40000000 -> next cycle fpu_op=8, pending=0x00000008. Model fpu_valid 3 cycles later with 0x40400000, alu_wr_en=0 -> wb_en=1, wb_dest=3, wb_data=0x40400000 same cycle. pending=0 the cycle after.
- RAW: mul dest r5, then add with src_a=r5 held valid -> issue_ready=0 until the cycle after r5 writeback. WAW with dest r5 is likewise blocked. An op with src r6 issues immediately.
- alu_wr_en held high for 6 cycles while 4 results return (WB_DEPTH=4) -> wb_en=0 throughout and a 5th fire is refused. After release, 4 consecutive writes occur in issue order with one per cycle.
- Div: fire div while fpu_div_busy=0 -> the next cycle div is refused (fpu_op==B), and it stays refused while fpu_div_busy=1. A mul (op A) is accepted during that time.
- Assert reset with 2 ops in flight and r7 pending -> pending=0, fpu_op=0. Late fpu_valid arrivals produce no wb_en and inflight stays 0.
- Fire op 4 -> issue_ready=1, bad_op pulses once, fpu_op stays 0, pending unchanged. Fire op D with dest 0 -> no pending bit, and its result produces no wb_en.
